alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-cycle operation sequencer that owns one shared 4-bit carry-lookahead adder/subtractor instance.
- The adder instance is external and has inputs A, B, M (0 = add, 1 = subtract) and outputs S, Cout.
- Executes ADD and SUB in a single pass, MUL as 4-step shift-add, and DIV as 4-step restoring division, driving the adder on every step.
- Sits between the ALU front-end (start/op handshake) and the adder datapath.

Parameters:
- WIDTH, 4, operand width; must match the adder. All widths below are stated for WIDTH=4.
- STEPS, 4, iteration count for MUL/DIV; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- a  in  4  operand A / multiplicand / dividend
- b  in  4  operand B / multiplier / divisor
- busy  out  1  high from the cycle after acceptance through the done cycle
- done  out  1  one-cycle completion pulse
- result  out  8  registered result; held until the next done
- flag  out  1  ADD: carry; SUB: borrow; DIV: divide-by-zero; MUL: 0
- add_a  out  4  to adder A
- add_b  out  4  to adder B
- add_m  out  1  to adder M
- add_s  in  4  from adder S
- add_cout  in  1  from adder Cout

Behaviour:
- Clock and reset: one clock domain. rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, flag=0, add_a=0, add_b=0, add_m=0.
- Reset mid-operation: return to IDLE, discard the operation, no done pulse.
- FSM states:
  - IDLE: if start=1, latch op/a/b, clear step counter, go to EXEC.
  - EXEC: one adder pass per cycle. Go to FIN after the last pass.
  - FIN: register result/flag, done=1 for this cycle only, go to IDLE.
- start is ignored in EXEC and FIN. It is not queued.
- Latency, with start accepted in cycle N:
  - ADD/SUB and DIV-by-zero: done in cycle N+2.
  - MUL/DIV: done in cycle N+5.
- Adder drive: add_a/add_b/add_m are combinational from the state registers. All three are 0 in IDLE and FIN.
- ADD: add_a=a, add_b=b, add_m=0. result={3'b0,add_cout,add_s}, flag=add_cout.
- SUB: add_a=a, add_b=b, add_m=1. result={4'b0,add_s}, flag=~add_cout (borrow).
- MUL: 8-bit register P, initialised to {4'b0,b}.
  - Each step: add_a=P[7:4], add_b=a, add_m=0.
  - If P[0]=1: P={add_cout,add_s,P[3:1]}. Otherwise: P={1'b0,P[7:1]}.
  - After 4 steps: result=P, flag=0.
- DIV: remainder R=0 and quotient Q=a initially.
  - Each step: T={R[2:0],Q[3]}, hi=R[3]; add_a=T, add_b=b, add_m=1.
  - If hi|add_cout: R=add_s, Q={Q[2:0],1}. Otherwise: R=T, Q={Q[2:0],0}.
  - After 4 steps: result={R,Q}, flag=0.
- DIV with b=0: no iterations. One EXEC cycle, then result={a,4'hF}, flag=1.
- Operand stability: a and b may change after acceptance without affecting the operation in progress.
- Output hold: result and flag update only at done and hold otherwise. done never asserts for two consecutive cycles.

Test Plan:
- ADD a=15, b=1 at N -> done at N+2, result=0x10, flag=1. ADD a=3, b=1 -> result=0x04, flag=0.
- SUB a=6, b=3 -> result=0x03, flag=0. SUB a=1, b=2 -> result=0x0F, flag=1. In both cases add_m=1 during EXEC.
- MUL a=15, b=15 -> done at N+5, result=0xE1. MUL a=13, b=11 -> result=0x8F. busy high N+1..N+5.
- DIV a=13, b=4 -> done at N+5, result=0x13 (R=1, Q=3). DIV a=9, b=0 -> done at N+2, result=0x9F, flag=1.
- Start ignored while busy: start MUL 13×11, then pulse start with ADD at N+2 -> only one done, at N+5, result=0x8F.
- Reset mid-operation: assert rst at N+3 of a MUL -> next cycle busy=0, result=0, no done. A following ADD 5+3 then gives result=0x08.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Multi-cycle operation sequencer that owns one external, shared
// carry-lookahead adder/subtractor. Operations:
//   op=00 ADD : one adder pass, result={0,cout,sum}, flag=carry
//   op=01 SUB : one adder pass, result={0,sum},      flag=borrow
//   op=10 MUL : STEPS shift-add passes,              flag=0
//   op=11 DIV : STEPS restoring-division passes, result={rem,quot}, flag=0
//               (divisor 0: no passes, result={a,all-ones}, flag=1)
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, op, a, b     request handshake; sampled only while idle
//   busy                high from the cycle after acceptance through done
//   done                one-cycle completion pulse
//   result, flag        registered outcome, held until the next done
//   add_a/add_b/add_m   drive to the shared adder (m: 0 add, 1 subtract)
//   add_s/add_cout      sum and carry-out back from the shared adder
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int STEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_m,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // Shared working register: product P for MUL, {R,Q} for DIV.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SW-1:0]        step_q, step_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 flag_q, flag_d;

  // Datapath helpers computed from the current pass.
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   res_calc;
  logic                 flag_calc;
  logic                 last_pass;
  logic [WIDTH-1:0]     drv_a, drv_b;
  logic                 drv_m;
  logic [WIDTH-1:0]     div_t;
  logic                 div_hi;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-pass datapath: adder drive, next working value, final result
  // -------------------------------------------------------------------------
  always_comb begin
    drv_a     = '0;
    drv_b     = '0;
    drv_m     = 1'b0;
    acc_step  = acc_q;
    res_calc  = '0;
    flag_calc = 1'b0;
    last_pass = 1'b1;
    // Restoring division: shift the next dividend bit into the partial
    // remainder; the bit shifted out of R is kept as an implicit 5th bit.
    div_t     = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
    div_hi    = acc_q[2*WIDTH-1];

    case (op_q)
      OP_ADD: begin
        drv_a     = a_q;
        drv_b     = b_q;
        drv_m     = 1'b0;
        res_calc  = {{(WIDTH-1){1'b0}}, add_cout, add_s};
        flag_calc = add_cout;
      end
      OP_SUB: begin
        drv_a     = a_q;
        drv_b     = b_q;
        drv_m     = 1'b1;
        res_calc  = {{WIDTH{1'b0}}, add_s};
        // Adder computes a + ~b + 1, so carry-out is "no borrow".
        flag_calc = ~add_cout;
      end
      OP_MUL: begin
        drv_a     = acc_q[2*WIDTH-1:WIDTH];
        drv_b     = a_q;
        drv_m     = 1'b0;
        if (acc_q[0]) begin
          acc_step = {add_cout, add_s, acc_q[WIDTH-1:1]};
        end else begin
          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        last_pass = (step_q == SW'(STEPS - 1));
        res_calc  = acc_step;
        flag_calc = 1'b0;
      end
      default: begin // OP_DIV
        drv_a = div_t;
        drv_b = b_q;
        drv_m = 1'b1;
        if (div_hi | add_cout) begin
          acc_step = {add_s, acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_step = {div_t, acc_q[WIDTH-2:0], 1'b0};
        end
        if (b_q == '0) begin
          // Divide-by-zero short-circuits after a single EXEC cycle.
          last_pass = 1'b1;
          res_calc  = {a_q, {WIDTH{1'b1}}};
          flag_calc = 1'b1;
        end else begin
          last_pass = (step_q == SW'(STEPS - 1));
          res_calc  = acc_step;
          flag_calc = 1'b0;
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          step_d  = '0;
          acc_d   = (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d  = acc_step;
        step_d = step_q + 1'b1;
        if (last_pass) begin
          // Result lands at the FIN edge so it is visible alongside done.
          result_d = res_calc;
          flag_d   = flag_calc;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    add_a = '0;
    add_b = '0;
    add_m = 1'b0;
    if (state_q == S_EXEC) begin
      add_a = drv_a;
      add_b = drv_b;
      add_m = drv_m;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_FIN);
  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Directed bench for alu_seq_ctrl. A behavioural 4-bit adder/subtractor
// stands in for the shared carry-lookahead adder. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       flag;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_m;
  logic [3:0] add_s;
  logic       add_cout;

  int checks   = 0;
  int failures = 0;

  alu_seq_ctrl #(.WIDTH(4), .STEPS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag     (flag),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_m    (add_m),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Adder/subtractor model: S,Cout = A + (M ? ~B : B) + M
  logic [4:0] add_sum;
  assign add_sum  = {1'b0, add_a} + {1'b0, (add_m ? ~add_b : add_b)} + {4'b0, add_m};
  assign add_s    = add_sum[3:0];
  assign add_cout = add_sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, then scramble operands to prove they were latched.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] x,
                        input logic [3:0] y, input int lat, input logic [7:0] er,
                        input logic ef);
    int c;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    c = 1;
    chk({tag, "_addm"}, 32'(add_m), 32'(o[0]));
    if (o[1] == 1'b0) begin
      chk({tag, "_adda"}, 32'(add_a), 32'(x));
      chk({tag, "_addb"}, 32'(add_b), 32'(y));
    end
    while (!done && c < 10) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      c++;
    end
    chk({tag, "_lat"},  32'(c),      32'(lat));
    chk({tag, "_res"},  32'(result), 32'(er));
    chk({tag, "_flag"}, 32'(flag),   32'(ef));
    $display("op=%0d a=%0d b=%0d -> result=0x%02h flag=%0d latency=%0d", o, x, y, result, flag, c);
    tick();
    chk({tag, "_done1"}, 32'(done),   32'd0);
    chk({tag, "_idle"},  32'(busy),   32'd0);
    chk({tag, "_hold"},  32'(result), 32'(er));
  endtask

  initial begin
    int ndone;
    int cdone;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 4'd0; b = 4'd0;
    repeat (3) tick();
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flag",   32'(flag),   32'd0);
    chk("rst_adda",   32'(add_a),  32'd0);
    chk("rst_addb",   32'(add_b),  32'd0);
    chk("rst_addm",   32'(add_m),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add15_1", 2'b00, 4'd15, 4'd1,  2, 8'h10, 1'b1);
    run_op("add3_1",  2'b00, 4'd3,  4'd1,  2, 8'h04, 1'b0);
    run_op("sub6_3",  2'b01, 4'd6,  4'd3,  2, 8'h03, 1'b0);
    run_op("sub1_2",  2'b01, 4'd1,  4'd2,  2, 8'h0F, 1'b1);
    run_op("mul15_15",2'b10, 4'd15, 4'd15, 5, 8'hE1, 1'b0);
    run_op("mul13_11",2'b10, 4'd13, 4'd11, 5, 8'h8F, 1'b0);
    run_op("mul0_7",  2'b10, 4'd0,  4'd7,  5, 8'h00, 1'b0);
    run_op("div13_4", 2'b11, 4'd13, 4'd4,  5, 8'h13, 1'b0);
    run_op("div9_0",  2'b11, 4'd9,  4'd0,  2, 8'h9F, 1'b1);
    run_op("div15_3", 2'b11, 4'd15, 4'd3,  5, 8'h05, 1'b0);
    run_op("div7_9",  2'b11, 4'd7,  4'd9,  5, 8'h70, 1'b0);

    // start pulsed mid-MUL must be ignored: exactly one done at N+5.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 4'd13; b = 4'd11;
    tick();
    start = 1'b0;
    ndone = 0; cdone = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        ndone++;
        cdone = c;
        chk("ign_res", 32'(result), 32'h8F);
      end
      if (c == 2) begin
        start = 1'b1; op = 2'b00; a = 4'd5; b = 4'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_cycle", 32'(cdone), 32'd5);
    $display("ignore-start: dones=%0d at cycle N+%0d result=0x%02h", ndone, cdone, result);

    // Reset in cycle N+3 of a MUL: idle next cycle, result cleared, no done.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 4'd13; b = 4'd11;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy",   32'(busy),   32'd0);
    chk("rstmid_result", 32'(result), 32'd0);
    chk("rstmid_done",   32'(done),   32'd0);
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("rstmid_nodone", 32'(ndone), 32'd0);
    $display("reset-mid-op: busy=%0d result=0x%02h dones=%0d", busy, result, ndone);
    run_op("add5_3", 2'b00, 4'd5, 4'd3, 2, 8'h08, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
